// File: rtl/npf_mac_sequencer.sv
// ============================================================================
// npf_mac_sequencer
// ----------------------------------------------------------------------------
// Purpose:
//   Sequencer for the narrow-bandpass IIR section
//       y[n] = x[n] - x[n-2] + C1*y[n-1] + C2*y[n-2]
//   The two feedback taps share a single 20x20 signed multiplier. Each
//   sample takes two multiply cycles. The block owns the x/y delay lines
//   and the runtime-programmable coefficient registers. An RTS/RTR handshake
//   connects it to the AM demodulator front end (DIN) and to the audio
//   output stage (DOUT).
//
// Ports:
//   CLK       in   1   clock
//   RESET     in   1   synchronous, active-high reset
//   DIN_DAT   in   20  signed input sample x[n]
//   DIN_RTS   in   1   upstream has a sample
//   DIN_RTR   out  1   block can accept a sample (high only in IDLE)
//   DOUT_DAT  out  16  signed filtered sample, y[n] >>> OUT_SHIFT
//   DOUT_RTS  out  1   DOUT_DAT is valid
//   DOUT_RTR  in   1   downstream can accept
//   CFG_WE    in   1   coefficient write strobe
//   CFG_SEL   in   1   0 = C1 shadow, 1 = C2 shadow
//   CFG_DATA  in   20  signed Q2.18 coefficient value
// ============================================================================
module npf_mac_sequencer #(
    parameter int                 COEF_FRAC = 18,
    parameter int                 ACC_W     = 24,
    parameter int                 OUT_SHIFT = 4,
    parameter logic signed [19:0] C1_INIT   = 20'sd134218,
    parameter logic signed [19:0] C2_INIT   = -20'sd256901
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic signed [19:0] DIN_DAT,
    input  logic               DIN_RTS,
    output logic               DIN_RTR,
    output logic signed [15:0] DOUT_DAT,
    output logic               DOUT_RTS,
    input  logic               DOUT_RTR,
    input  logic               CFG_WE,
    input  logic               CFG_SEL,
    input  logic signed [19:0] CFG_DATA
);

    // 20-bit saturation limits, expressed at accumulator width so that the
    // comparison happens before the result is narrowed.
    localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'(524287);
    localparam logic signed [ACC_W-1:0] Y_MIN = ACC_W'(-524288);

    typedef enum logic [1:0] {
        IDLE,
        MUL1,
        MUL2,
        OUT
    } state_t;

    state_t state;

    // Delay lines and the sample currently being processed
    logic signed [19:0] x_cur;
    logic signed [19:0] x1;
    logic signed [19:0] x2;
    logic signed [19:0] y1;
    logic signed [19:0] y2;

    // Coefficients: shadows are written by CFG at any time. Actives are
    // loaded from the shadows only when a sample is accepted.
    logic signed [19:0] c1_shadow;
    logic signed [19:0] c2_shadow;
    logic signed [19:0] c1_active;
    logic signed [19:0] c2_active;

    logic signed [ACC_W-1:0] acc;

    // Shared multiplier datapath
    logic signed [19:0]      mul_a;
    logic signed [19:0]      mul_b;
    logic signed [39:0]      product;
    logic signed [ACC_W-1:0] prod_term;
    logic signed [ACC_W-1:0] acc_sum;
    logic signed [19:0]      y_new;

    logic in_xfc;
    logic out_xfc;

    assign in_xfc  = DIN_RTS & DIN_RTR;
    assign out_xfc = DOUT_RTS & DOUT_RTR;

    // Operand mux for the single multiplier. MUL2 takes the C2/y2 tap and
    // every other state takes the C1/y1 tap. The shift is arithmetic, so the
    // scaled product rounds toward minus infinity. The truncation to ACC_W
    // is safe because |C| <= 2 and |y| <= 2^19.
    always_comb begin
        mul_a = c1_active;
        mul_b = y1;
        if (state == MUL2) begin
            mul_a = c2_active;
            mul_b = y2;
        end
        product   = mul_a * mul_b;
        prod_term = ACC_W'(product >>> COEF_FRAC);
        acc_sum   = acc + prod_term;

        if (acc_sum > Y_MAX) begin
            y_new = 20'sh7FFFF;
        end else if (acc_sum < Y_MIN) begin
            y_new = 20'sh80000;
        end else begin
            y_new = 20'(acc_sum);
        end
    end

    // Main sequencer. The handshake outputs and DOUT_DAT are registered.
    // The x/y delay lines advance only in MUL2, so a stalled OUT state
    // leaves the filter history untouched.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            DIN_RTR   <= 1'b1;
            DOUT_RTS  <= 1'b0;
            DOUT_DAT  <= '0;
            x_cur     <= '0;
            x1        <= '0;
            x2        <= '0;
            y1        <= '0;
            y2        <= '0;
            acc       <= '0;
            c1_shadow <= C1_INIT;
            c2_shadow <= C2_INIT;
            c1_active <= C1_INIT;
            c2_active <= C2_INIT;
        end else begin
            // A shadow write in the same cycle as an accepted sample does not
            // reach the active registers until the next sample is accepted.
            if (CFG_WE) begin
                if (CFG_SEL) begin
                    c2_shadow <= CFG_DATA;
                end else begin
                    c1_shadow <= CFG_DATA;
                end
            end

            case (state)
                IDLE: begin
                    if (in_xfc) begin
                        acc       <= ACC_W'(DIN_DAT) - ACC_W'(x2);
                        x_cur     <= DIN_DAT;
                        c1_active <= c1_shadow;
                        c2_active <= c2_shadow;
                        DIN_RTR   <= 1'b0;
                        state     <= MUL1;
                    end
                end

                MUL1: begin
                    acc   <= acc_sum;
                    state <= MUL2;
                end

                MUL2: begin
                    y2       <= y1;
                    y1       <= y_new;
                    x2       <= x1;
                    x1       <= x_cur;
                    DOUT_DAT <= 16'(y_new >>> OUT_SHIFT);
                    DOUT_RTS <= 1'b1;
                    state    <= OUT;
                end

                OUT: begin
                    if (out_xfc) begin
                        DOUT_RTS <= 1'b0;
                        DIN_RTR  <= 1'b1;
                        state    <= IDLE;
                    end
                end

                default: begin
                    DIN_RTR  <= 1'b1;
                    DOUT_RTS <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_npf_mac_sequencer.sv
// ============================================================================
// tb_npf_mac_sequencer
// ----------------------------------------------------------------------------
// Purpose:
//   Self-checking bench for npf_mac_sequencer. The expected outputs come from
//   a plain arithmetic model of the difference equation, which uses floor
//   division and clamping. Coverage includes impulse response, handshake
//   cadence, backpressure, saturation, coefficient update timing, reset
//   during a sample, and randomized samples and coefficients.
// Ports: none (top-level bench).
// ============================================================================
module tb_npf_mac_sequencer;

    logic               CLK = 1'b0;
    logic               RESET;
    logic signed [19:0] DIN_DAT;
    logic               DIN_RTS;
    logic               DIN_RTR;
    logic signed [15:0] DOUT_DAT;
    logic               DOUT_RTS;
    logic               DOUT_RTR;
    logic               CFG_WE;
    logic               CFG_SEL;
    logic signed [19:0] CFG_DATA;

    int checks = 0;
    int errors = 0;

    // Reference model state: sample history plus shadow and active coefficients
    longint mx1, mx2, my1, my2;
    longint mc1s, mc2s, mc1a, mc2a;

    npf_mac_sequencer dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .DIN_DAT  (DIN_DAT),
        .DIN_RTS  (DIN_RTS),
        .DIN_RTR  (DIN_RTR),
        .DOUT_DAT (DOUT_DAT),
        .DOUT_RTS (DOUT_RTS),
        .DOUT_RTR (DOUT_RTR),
        .CFG_WE   (CFG_WE),
        .CFG_SEL  (CFG_SEL),
        .CFG_DATA (CFG_DATA)
    );

    always #5 CLK = ~CLK;

    function automatic longint floorDiv(input longint p, input longint d);
        if (p >= 0) return p / d;
        return -((-p + d - 1) / d);
    endfunction

    function automatic longint clamp20(input longint v);
        if (v > 524287)  return 524287;
        if (v < -524288) return -524288;
        return v;
    endfunction

    task automatic modelReset();
        mx1 = 0; mx2 = 0; my1 = 0; my2 = 0;
        mc1s = 134218;  mc1a = 134218;
        mc2s = -256901; mc2a = -256901;
    endtask

    // One sample through the difference equation, using the active coefficients
    task automatic modelStep(input longint x, output longint y);
        y = clamp20(x - mx2 + floorDiv(mc1a * my1, 262144) + floorDiv(mc2a * my2, 262144));
        my2 = my1; my1 = y;
        mx2 = mx1; mx1 = x;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                               input logic signed [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic doReset();
        RESET = 1'b1;
        DIN_RTS = 1'b0; DOUT_RTR = 1'b0; CFG_WE = 1'b0;
        tick();
        tick();
        RESET = 1'b0;
        modelReset();
    endtask

    task automatic cfgWrite(input logic sel, input longint val);
        CFG_WE = 1'b1; CFG_SEL = sel; CFG_DATA = 20'(val);
        tick();
        CFG_WE = 1'b0;
        if (sel) mc2s = val; else mc1s = val;
    endtask

    // Sends one sample and follows it to the output transfer.
    // cfgPhase: 0 = no write, 1 = write in the accept cycle, 2 = write in MUL1.
    task automatic applyStimulus(input longint x, input int stall, input int cfgPhase,
                                 input logic cfgSel, input longint cfgVal,
                                 output logic signed [15:0] obs);
        longint y;
        int     expDout;
        checkOutput("din_rtr_idle", 32'(DIN_RTR), 32'sd1);
        DOUT_RTR = 1'b0;
        DIN_DAT  = 20'(x);
        DIN_RTS  = 1'b1;
        if (cfgPhase == 1) begin
            CFG_WE = 1'b1; CFG_SEL = cfgSel; CFG_DATA = 20'(cfgVal);
        end
        mc1a = mc1s; mc2a = mc2s;
        modelStep(x, y);
        if (cfgPhase != 0) begin
            if (cfgSel) mc2s = cfgVal; else mc1s = cfgVal;
        end
        expDout = int'(floorDiv(y, 16));
        tick();
        DIN_RTS = 1'b0;
        CFG_WE  = 1'b0;
        DIN_DAT = 20'($urandom);
        checkOutput("rts_mul1", 32'(DOUT_RTS), 32'sd0);
        checkOutput("din_rtr_busy", 32'(DIN_RTR), 32'sd0);
        if (cfgPhase == 2) begin
            CFG_WE = 1'b1; CFG_SEL = cfgSel; CFG_DATA = 20'(cfgVal);
        end
        tick();
        CFG_WE = 1'b0;
        checkOutput("rts_mul2", 32'(DOUT_RTS), 32'sd0);
        tick();
        checkOutput("rts_out", 32'(DOUT_RTS), 32'sd1);
        checkOutput("dout_dat", 32'(DOUT_DAT), expDout);
        obs = DOUT_DAT;
        for (int i = 0; i < stall; i++) begin
            tick();
            checkOutput("stall_rts", 32'(DOUT_RTS), 32'sd1);
            checkOutput("stall_dat", 32'(DOUT_DAT), expDout);
            checkOutput("stall_din_rtr", 32'(DIN_RTR), 32'sd0);
        end
        DOUT_RTR = 1'b1;
        tick();
        DOUT_RTR = 1'b0;
        checkOutput("rts_after_xfc", 32'(DOUT_RTS), 32'sd0);
        checkOutput("din_rtr_after_xfc", 32'(DIN_RTR), 32'sd1);
    endtask

    initial begin
        logic signed [15:0] obs;
        longint             y;
        longint             pendY;
        RESET = 1'b0; DIN_DAT = '0; DIN_RTS = 1'b0; DOUT_RTR = 1'b0;
        CFG_WE = 1'b0; CFG_SEL = 1'b0; CFG_DATA = '0;
        pendY = 0;

        // Reset state
        doReset();
        checkOutput("reset_din_rtr", 32'(DIN_RTR), 32'sd1);
        checkOutput("reset_dout_rts", 32'(DOUT_RTS), 32'sd0);
        checkOutput("reset_dout_dat", 32'(DOUT_DAT), 32'sd0);

        // Impulse response with the default coefficients
        $display("[TB] impulse with default coefficients");
        applyStimulus(1000, 0, 0, 1'b0, 0, obs); checkOutput("impulse_0", 32'(obs), 32'sd62);
        applyStimulus(0, 0, 0, 1'b0, 0, obs);    checkOutput("impulse_1", 32'(obs), 32'sd32);
        applyStimulus(0, 0, 0, 1'b0, 0, obs);    checkOutput("impulse_2", 32'(obs), -32'sd108);

        // Continuous handshake: DIN_RTS and DOUT_RTR held high
        $display("[TB] continuous handshake cadence");
        DIN_RTS = 1'b1; DOUT_RTR = 1'b1;
        for (int c = 0; c < 16; c++) begin
            DIN_DAT = 20'($urandom);
            checkOutput("hs_din_rtr", 32'(DIN_RTR), (c % 4 == 0) ? 32'sd1 : 32'sd0);
            checkOutput("hs_dout_rts", 32'(DOUT_RTS), (c % 4 == 3) ? 32'sd1 : 32'sd0);
            if (c % 4 == 0) begin
                mc1a = mc1s; mc2a = mc2s;
                modelStep(longint'(DIN_DAT), y);
                pendY = y;
            end
            if (c % 4 == 3) checkOutput("hs_dout", 32'(DOUT_DAT), 32'(floorDiv(pendY, 16)));
            tick();
            if (c == 15) begin
                DIN_RTS = 1'b0; DOUT_RTR = 1'b0;
            end
        end

        // Random samples with random backpressure
        $display("[TB] random samples with backpressure");
        applyStimulus(longint'($urandom_range(0, 1048575)) - 524288, 10, 0, 1'b0, 0, obs);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(longint'($urandom_range(0, 1048575)) - 524288,
                          int'($urandom_range(0, 3)), 0, 1'b0, 0, obs);
        end

        // Saturation with zero coefficients, positive then negative
        $display("[TB] saturation");
        doReset();
        cfgWrite(1'b0, 0);
        cfgWrite(1'b1, 0);
        applyStimulus(-524288, 0, 0, 1'b0, 0, obs);
        applyStimulus(0, 0, 0, 1'b0, 0, obs);
        applyStimulus(524287, 0, 0, 1'b0, 0, obs);  checkOutput("sat_pos", 32'(obs), 32'sd32767);
        applyStimulus(524287, 0, 0, 1'b0, 0, obs);
        applyStimulus(0, 0, 0, 1'b0, 0, obs);
        applyStimulus(-524288, 0, 0, 1'b0, 0, obs); checkOutput("sat_neg", 32'(obs), -32'sd32768);

        // Coefficient update timing
        $display("[TB] coefficient update timing");
        doReset();
        applyStimulus(200000, 0, 0, 1'b0, 0, obs);
        applyStimulus(0, 0, 2, 1'b0, 0, obs);        // write C1=0 during MUL1
        checkOutput("cfg_mul1_old", 32'(obs), 32'(floorDiv(floorDiv(134218 * 200000, 262144), 16)));
        applyStimulus(0, 0, 0, 1'b0, 0, obs);        // C1=0 now active
        applyStimulus(150000, 0, 1, 1'b0, 77777, obs); // write coincident with accept
        applyStimulus(0, 0, 0, 1'b0, 0, obs);
        applyStimulus(0, 1, 1, 1'b1, -100000, obs);
        applyStimulus(0, 0, 0, 1'b0, 0, obs);

        // Random coefficients and in-flight writes
        $display("[TB] random coefficients");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(longint'($urandom_range(0, 1048575)) - 524288,
                          int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                          1'($urandom_range(0, 1)),
                          longint'($urandom_range(0, 1048575)) - 524288, obs);
        end

        // Reset during MUL2 discards the sample
        $display("[TB] reset mid-sample");
        DIN_DAT = 20'sd5555; DIN_RTS = 1'b1;
        tick();
        DIN_RTS = 1'b0;
        tick();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        modelReset();
        for (int i = 0; i < 4; i++) begin
            checkOutput("abort_dout_rts", 32'(DOUT_RTS), 32'sd0);
            tick();
        end
        checkOutput("abort_din_rtr", 32'(DIN_RTR), 32'sd1);
        checkOutput("abort_dout_dat", 32'(DOUT_DAT), 32'sd0);
        applyStimulus(1000, 0, 0, 1'b0, 0, obs); checkOutput("post_rst_0", 32'(obs), 32'sd62);
        applyStimulus(0, 0, 0, 1'b0, 0, obs);    checkOutput("post_rst_1", 32'(obs), 32'sd32);
        applyStimulus(0, 0, 0, 1'b0, 0, obs);    checkOutput("post_rst_2", 32'(obs), -32'sd108);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
